// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule sequencer: one shared KeyGeneration step per clock,
// round keys 0..NR held in a store with random-access reads. Optional KS_ZEROIZE_EN adds a zeroize input.
module aes_key_sched_ctrl #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef KS_ZEROIZE_EN
  input  logic             zeroize,
`endif
  input  logic             load,
  input  logic [127:0]     key_in,
  output logic             load_ack,
  output logic             busy,
  output logic             keys_valid,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [127:0]     rd_key,
  output logic             rd_err
);

  localparam logic [IDX_W-1:0] NR_L = IDX_W'(NR);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t                 state, state_n;
  logic [IDX_W-1:0]       rnd, rnd_m1;
  logic [NR:0][127:0]     store;
  logic [127:0]           kg_key, kg_out;
  logic                   zap;

`ifdef KS_ZEROIZE_EN
  assign zap = zeroize;
`else
  assign zap = 1'b0;
`endif

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  // S-box as GF(2^8) inverse (x^254 = x^2 * x^4 * ... * x^128) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    case (rc)
      4'd0: return 8'h01;
      4'd1: return 8'h02;
      4'd2: return 8'h04;
      4'd3: return 8'h08;
      4'd4: return 8'h10;
      4'd5: return 8'h20;
      4'd6: return 8'h40;
      4'd7: return 8'h80;
      4'd8: return 8'h1b;
      4'd9: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_gen(input logic [127:0] k, input logic [3:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    t[31:24] = t[31:24] ^ rcon(rc);
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Single KeyGeneration instance fed from the previous round's store entry.
  assign rnd_m1 = rnd - 1'b1;
  assign kg_key = (rnd_m1 <= NR_L) ? store[rnd_m1] : '0;
  assign kg_out = key_gen(kg_key, 4'(rnd_m1));
  assign busy   = (state == EXPAND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    load_ack = 1'b0;
    case (state)
      IDLE, READY: if (load && !zap) begin
        load_ack = 1'b1;
        state_n  = EXPAND;
      end
      EXPAND: if (rnd == NR_L) state_n = READY;
      default: state_n = IDLE;
    endcase
    if (zap) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store      <= '0;
      rnd        <= '0;
      keys_valid <= 1'b0;
      rd_valid   <= 1'b0;
      rd_key     <= '0;
      rd_err     <= 1'b0;
    end else if (zap) begin
      store      <= '0;
      rnd        <= '0;
      keys_valid <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      // Reads see pre-edge store/keys_valid, so a same-edge load never corrupts the read.
      if (rd_en) begin
        rd_valid <= 1'b1;
        if (rd_idx > NR_L || !keys_valid) begin
          rd_key <= '0;
          rd_err <= 1'b1;
        end else begin
          rd_key <= store[rd_idx];
          rd_err <= 1'b0;
        end
      end else begin
        rd_valid <= 1'b0;
      end

      if (load_ack) begin
        store[0]   <= key_in;
        rnd        <= IDX_W'(1);
        keys_valid <= 1'b0;
      end else if (state == EXPAND) begin
        store[rnd] <= kg_out;
        rnd        <= rnd + 1'b1;
        if (rnd == NR_L) keys_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: directed FIPS-197 vectors plus random load/read traffic
// checked against a word-level key-expansion model.
module tb_aes_key_sched_ctrl;
  localparam int NR = 10, IDX_W = 4;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic             clk = 1'b0, rst = 1'b0, load = 1'b0, rd_en = 1'b0;
  logic [127:0]     key_in = '0, rd_key;
  logic [IDX_W-1:0] rd_idx = '0;
  logic             load_ack, busy, keys_valid, rd_valid, rd_err;
`ifdef KS_ZEROIZE_EN
  logic             zeroize = 1'b0;
`endif

  always #5 clk = ~clk;

  aes_key_sched_ctrl #(.NR(NR), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
`ifdef KS_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .load(load), .key_in(key_in), .load_ack(load_ack), .busy(busy), .keys_valid(keys_valid),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_key(rd_key), .rd_err(rd_err)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // reference model
  logic [7:0]   sb [256];
  logic [7:0]   rcon [10];
  logic [127:0] m_sched [0:10], m_pend [0:10];
  bit           m_valid;
  int           m_cnt;
  logic [127:0] e_key;
  bit           e_valid, e_err;

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] p, q, x, rc;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    rc = 8'h01;
    for (int i = 0; i < 10; i++) begin
      rcon[i] = rc;
      rc = (rc << 1) ^ (rc[7] ? 8'h1b : 8'h00);
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon[i/4-1];
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) m_pend[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic model_reset();
    m_valid = 0; m_cnt = 0; e_valid = 0; e_key = '0; e_err = 0;
    for (int r = 0; r <= NR; r++) m_sched[r] = '0;
  endtask

  // Called ~1 time unit after a posedge with inputs already set; advances one clock.
  task automatic tick();
    bit acc, zz;
    zz = 0;
`ifdef KS_ZEROIZE_EN
    zz = zeroize;
`endif
    #1;
    acc = load && (m_cnt == 0) && !zz;
    chk("load_ack", load_ack, acc);
    if (zz) begin
      e_valid = 0; m_valid = 0; m_cnt = 0;
    end else begin
      if (rd_en) begin
        e_valid = 1;
        if (int'(rd_idx) > NR || !m_valid) begin e_key = '0; e_err = 1; end
        else begin e_key = m_sched[rd_idx]; e_err = 0; end
      end else e_valid = 0;
      if (acc) begin
        expand(key_in); m_cnt = NR; m_valid = 0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin m_sched = m_pend; m_valid = 1; end
      end
    end
    @(posedge clk); #1;
    chk("rd_valid", rd_valid, e_valid);
    chk("rd_key", rd_key, e_key);
    chk("rd_err", rd_err, e_err);
    chk("busy", busy, m_cnt != 0);
    chk("keys_valid", keys_valid, m_valid);
  endtask

  task automatic idle_in();
    load = 0; rd_en = 0;
  endtask

  task automatic wait_valid();
    idle_in();
    for (int i = 0; i < 20 && !keys_valid; i++) tick();
    chk("kv_timeout", keys_valid, 1'b1);
  endtask

  task automatic do_load(input logic [127:0] k);
    load = 1; key_in = k; rd_en = 0;
    tick();
    load = 0;
  endtask

  task automatic read1(input int idx);
    rd_en = 1; rd_idx = IDX_W'(idx);
    tick();
    rd_en = 0;
  endtask

  task automatic async_reset();
    rst = 1; #2;
    model_reset();
    chk("rst_busy", busy, 1'b0);
    chk("rst_kv", keys_valid, 1'b0);
    chk("rst_rdv", rd_valid, 1'b0);
    chk("rst_key", rd_key, '0);
    chk("rst_err", rd_err, 1'b0);
    rst = 0;
  endtask

  initial begin
    int run;
    build_tables();
    model_reset();
    #2;
    async_reset();
    @(posedge clk); #1;

    // read before any load
    read1(0);
    chk("pre_err", rd_err, 1'b1);

    // FIPS key: keys_valid exactly 10 clocks after load acceptance
    load = 1; key_in = FIPS_KEY;
    #1; chk("ack_fips", load_ack, 1'b1);
    tick(); load = 0;
    for (int i = 0; i < 9; i++) tick();
    chk("kv_lat9", keys_valid, 1'b0);
    tick();
    chk("kv_lat10", keys_valid, 1'b1);

    // reverse-order reads 10..0, back to back
    run = 0;
    for (int i = NR; i >= 0; i--) begin
      rd_en = 1; rd_idx = IDX_W'(i);
      tick();
      if (rd_valid) run++;
      if (i == 10) chk("fips_r10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      if (i == 1)  chk("fips_r1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
      if (i == 0)  chk("fips_r0", rd_key, FIPS_KEY);
    end
    chk("rdv_run", 128'(run), 128'd11);
    read1(11); chk("err11", rd_err, 1'b1);
    read1(15); chk("err15", rd_key, '0);
    idle_in(); tick();

    // load during EXPAND is ignored
    do_load(FIPS_KEY);
    for (int i = 0; i < 4; i++) tick();
    load = 1; key_in = '0;
    #1; chk("ack_ign", load_ack, 1'b0);
    tick(); load = 0;
    wait_valid();
    read1(10); chk("keep_r10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    do_load('0);
    wait_valid();
    read1(10); chk("zero_r10", rd_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // load + read same edge in READY: read served from old schedule
    load = 1; key_in = FIPS_KEY; rd_en = 1; rd_idx = 4'd10;
    tick();
    chk("ovl_r10", rd_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    idle_in();
    wait_valid();

    // reset mid-expansion
    do_load(128'h000102030405060708090a0b0c0d0e0f);
    for (int i = 0; i < 5; i++) tick();
    async_reset();
    read1(0); chk("rst_rd_err", rd_err, 1'b1);

`ifdef KS_ZEROIZE_EN
    do_load(FIPS_KEY);
    wait_valid();
    zeroize = 1; tick(); zeroize = 0;
    chk("zz_kv", keys_valid, 1'b0);
    read1(3);
    chk("zz_err", rd_err, 1'b1);
    chk("zz_key", rd_key, '0);
`endif

    // random traffic
    for (int c = 0; c < 600; c++) begin
      load   = ($urandom_range(0, 7) == 0);
      key_in = {$urandom, $urandom, $urandom, $urandom};
      rd_en  = $urandom_range(0, 1) == 1;
      rd_idx = IDX_W'($urandom_range(0, 15));
`ifdef KS_ZEROIZE_EN
      zeroize = ($urandom_range(0, 49) == 0);
`endif
      tick();
    end
`ifdef KS_ZEROIZE_EN
    zeroize = 0;
`endif
    idle_in();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
